multiplier_32b_reg: RTL and testbench

//   Unsigned 32x32 -> 64-bit multiplier with a registered output.

---
 rtl/multiplier_32b_reg_pkg.sv | 27 ++
 rtl/multiplier_32b_reg_if.sv | 27 ++
 rtl/multiplier_32b_reg_mul_array_32x32.sv | 51 +++++
 rtl/multiplier_32b_reg.sv | 30 +++
 tb/tb_multiplier_32b_reg.sv | 124 ++++++++++++
 5 files changed

// File: rtl/multiplier_32b_reg_pkg.sv
// Shared widths and carry-save helpers for the registered 32x32 unsigned multiplier.
package multiplier_32b_reg_pkg;

    localparam int DATA_W     = 32;
    localparam int PROD_W     = 2 * DATA_W;
    localparam int NUM_PP     = DATA_W;
    // 32 rows shrink 32->22->15->10->7->5->4->3->2 through the 3:2 tree.
    localparam int CSA_LEVELS = 8;

    function automatic logic [PROD_W-1:0] csa_sum(
        input logic [PROD_W-1:0] a,
        input logic [PROD_W-1:0] b,
        input logic [PROD_W-1:0] c
    );
        return a ^ b ^ c;
    endfunction

    // The top carry bit is dropped; the true product never exceeds PROD_W bits.
    function automatic logic [PROD_W-1:0] csa_carry(
        input logic [PROD_W-1:0] a,
        input logic [PROD_W-1:0] b,
        input logic [PROD_W-1:0] c
    );
        return ((a & b) | (a & c) | (b & c)) << 1;
    endfunction

endpackage

// File: rtl/multiplier_32b_reg_if.sv
// Operand/control/product bundle between a producer and the registered multiplier.
interface multiplier_32b_reg_if;
    import multiplier_32b_reg_pkg::*;

    logic              iEn;
    logic              iClr;
    logic [DATA_W-1:0] iData0;
    logic [DATA_W-1:0] iData1;
    logic [PROD_W-1:0] oData;

    modport master (
        output iEn,
        output iClr,
        output iData0,
        output iData1,
        input  oData
    );

    modport slave (
        input  iEn,
        input  iClr,
        input  iData0,
        input  iData1,
        output oData
    );

endinterface

// File: rtl/multiplier_32b_reg_mul_array_32x32.sv
// Combinational 32x32 unsigned array multiplier: partial products, 3:2 carry-save tree,
// one final carry-propagate add.
module mul_array_32x32
    import multiplier_32b_reg_pkg::*;
(
    input  logic [DATA_W-1:0] multiplicand,
    input  logic [DATA_W-1:0] multiplier,
    output logic [PROD_W-1:0] product
);

    logic [PROD_W-1:0] cur [NUM_PP];
    logic [PROD_W-1:0] nxt [NUM_PP];
    int                cnt;
    int                nxt_cnt;

    always_comb begin
        cur     = '{default: '0};
        nxt     = '{default: '0};
        cnt     = NUM_PP;
        nxt_cnt = 0;

        for (int i = 0; i < NUM_PP; i++) begin
            cur[i] = PROD_W'(multiplicand & {DATA_W{multiplier[i]}}) << i;
        end

        // Each level compresses every full group of three rows into two and
        // passes the remaining one or two rows straight through.
        for (int lvl = 0; lvl < CSA_LEVELS; lvl++) begin
            nxt     = '{default: '0};
            nxt_cnt = 0;
            for (int g = 0; g < NUM_PP / 3; g++) begin
                if (3 * g + 2 < cnt) begin
                    nxt[nxt_cnt]     = csa_sum(cur[3*g], cur[3*g+1], cur[3*g+2]);
                    nxt[nxt_cnt + 1] = csa_carry(cur[3*g], cur[3*g+1], cur[3*g+2]);
                    nxt_cnt          = nxt_cnt + 2;
                end
            end
            for (int r = 0; r < NUM_PP; r++) begin
                if (r >= (cnt / 3) * 3 && r < cnt) begin
                    nxt[nxt_cnt] = cur[r];
                    nxt_cnt      = nxt_cnt + 1;
                end
            end
            cur = nxt;
            cnt = nxt_cnt;
        end

        product = cur[0] + cur[1];
    end

endmodule

// File: rtl/multiplier_32b_reg.sv
// Unsigned 32x32 -> 64 multiplier with a product register (load enable, sync clear, async reset).
module multiplier_32b_reg
    import multiplier_32b_reg_pkg::*;
(
    input  logic                 iClk,
    input  logic                 iRst,
    multiplier_32b_reg_if.slave  bus
);

    logic [PROD_W-1:0] product;

    mul_array_32x32 u_mul_array (
        .multiplicand (bus.iData0),
        .multiplier   (bus.iData1),
        .product      (product)
    );

    // Clear wins over enable; with neither, the register holds, so operand X/Z
    // cannot leak into oData unless a load is actually requested.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            bus.oData <= '0;
        end else if (bus.iClr) begin
            bus.oData <= '0;
        end else if (bus.iEn) begin
            bus.oData <= product;
        end
    end

endmodule

// File: tb/tb_multiplier_32b_reg.sv
// Directed and random checks of the registered multiplier against a 64-bit reference model.
module tb_multiplier_32b_reg;
    import multiplier_32b_reg_pkg::*;

    logic clk = 1'b1;
    logic rst;

    always #5 clk = ~clk;

    multiplier_32b_reg_if bus ();

    multiplier_32b_reg dut (
        .iClk (clk),
        .iRst (rst),
        .bus  (bus)
    );

    logic [PROD_W-1:0] exp_q [$];
    logic [PROD_W-1:0] model_reg;
    int                errors = 0;
    int                checks = 0;

    task automatic check(input string tag, input logic [PROD_W-1:0] obs,
                         input logic [PROD_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs and push the register value expected after the next edge.
    task automatic drive(input logic en, input logic clr,
                         input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        bus.iEn    = en;
        bus.iClr   = clr;
        bus.iData0 = a;
        bus.iData1 = b;
        if (clr)     model_reg = '0;
        else if (en) model_reg = PROD_W'(a) * PROD_W'(b);
        exp_q.push_back(model_reg);
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: observed=%h expected=<empty scoreboard>", tag, bus.oData);
        end else begin
            check(tag, bus.oData, exp_q.pop_front());
        end
    endtask

    initial begin
        // Reset held for 15 ns with a load requested; the edge at 10 ns must not load.
        rst        = 1'b1;
        bus.iEn    = 1'b1;
        bus.iClr   = 1'b0;
        bus.iData0 = 32'd10;
        bus.iData1 = 32'd20;
        model_reg  = '0;
        #1;  check("reset_t1",  bus.oData, '0);
        #8;  check("reset_t9",  bus.oData, '0);
        #2;  check("reset_t11", bus.oData, '0);
        #3;  check("reset_t14", bus.oData, '0);
        #1;  rst = 1'b0;

        repeat (11) begin
            drive(1'b1, 1'b0, 32'd10, 32'd20);
            tick("basic_10x20");
        end

        for (int i = 0; i < 40; i++) begin
            drive(1'b1, 1'b1, $urandom, $urandom);
            tick("clear_held");
        end
        drive(1'b1, 1'b1, 'x, 'x);
        tick("clear_x_operands");

        drive(1'b1, 1'b0, 32'd7, 32'd6);
        tick("hold_load_7x6");
        repeat (5) begin
            drive(1'b0, 1'b0, 32'd3, 32'd3);
            tick("hold_42");
        end
        drive(1'b0, 1'b0, 'x, 'x);
        tick("hold_x_operands");

        drive(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        tick("max_x_max");
        check("max_x_max_const", bus.oData, 64'hFFFF_FFFE_0000_0001);
        drive(1'b1, 1'b0, 32'h8000_0000, 32'd2);
        tick("msb_x_2");
        check("msb_x_2_const", bus.oData, 64'h1_0000_0000);
        drive(1'b1, 1'b0, 32'd0, 32'hFFFF_FFFF);
        tick("zero_x_max");
        for (int i = 0; i < 24; i++) begin
            drive(1'b1, 1'b0, $urandom, $urandom);
            tick("random");
        end
        for (int i = 0; i < 8; i++) begin
            drive($urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0, $urandom, $urandom);
            tick("random_ctrl");
        end

        // Asynchronous reset pulsed between edges.
        drive(1'b1, 1'b0, 32'd10, 32'd20);
        tick("pre_async_reset");
        #2;  rst = 1'b1;
        #1;  check("async_reset_immediate", bus.oData, '0);
        model_reg = '0;
        #1;  rst = 1'b0;
        drive(1'b0, 1'b0, 32'd1, 32'd1);
        tick("post_reset_hold");
        drive(1'b1, 1'b0, 32'd5, 32'd5);
        tick("post_reset_load");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
